// File: rtl/display_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display.
// One shared BCD decoder; dead time between slots; frame-aligned updates.
module display_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000,
  parameter int GAP      = 16,
  parameter bit LZ_BLANK = 1'b1,
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int CW = $clog2(DIV)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  output logic [3:0]            bcd_out,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_SHOW = 2'd2;

  localparam logic [4*N_DIGITS-1:0] ALL_BLANK = {N_DIGITS{4'hF}};

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic [4*N_DIGITS-1:0] r_disp;
  logic                  r_pending;
  logic [N_DIGITS-1:0]   r_anodes;
  logic [3:0]            r_bcd;
  logic                  r_tick;

  logic [1:0]            w_state_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic                  w_last;
  logic                  w_wrap;
  logic                  w_commit;
  logic [4*N_DIGITS-1:0] w_disp_nxt;
  logic [4*N_DIGITS-1:0] w_shadow_nxt;
  logic                  w_pend_nxt;
  logic                  w_run;
  logic [3:0]            w_code;
  logic [N_DIGITS-1:0]   w_an_nxt;
  logic [3:0]            w_bcd_nxt;

  assign w_last = (r_idx == IW'(N_DIGITS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    if (!en) begin
      w_state_nxt = S_OFF;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      unique case (1'b1)
        (r_state == S_GAP): begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CW'(GAP - 1))
            w_state_nxt = S_SHOW;
        end
        (r_state == S_SHOW): begin
          if (r_cnt == CW'(DIV - 1)) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = '0;
            w_idx_nxt   = w_last ? '0 : r_idx + 1'b1;
            w_wrap      = w_last;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // The commit is visible to the digit-0 pre-drive on the same edge.
  assign w_commit     = w_wrap & r_pending;
  assign w_disp_nxt   = w_commit ? r_shadow : r_disp;
  assign w_shadow_nxt = load ? digits_in : r_shadow;
  assign w_pend_nxt   = load | (r_pending & ~w_commit);

  always_comb begin
    w_run  = 1'b1;
    w_code = 4'hF;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_run = w_run & (w_disp_nxt[4*i +: 4] == 4'h0);
      if (w_idx_nxt == IW'(i)) begin
        if (LZ_BLANK && (i != 0) && w_run)
          w_code = 4'hF;
        else
          w_code = w_disp_nxt[4*i +: 4];
      end
    end
  end

  always_comb begin
    w_an_nxt  = '1;
    w_bcd_nxt = 4'hF;
    if (w_state_nxt == S_SHOW)
      w_an_nxt = ~(N_DIGITS'(1) << w_idx_nxt);
    if (w_state_nxt != S_OFF)
      w_bcd_nxt = w_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_OFF;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shadow  <= ALL_BLANK;
      r_disp    <= ALL_BLANK;
      r_pending <= 1'b0;
      r_anodes  <= '1;
      r_bcd     <= 4'hF;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shadow  <= w_shadow_nxt;
      r_disp    <= w_disp_nxt;
      r_pending <= w_pend_nxt;
      r_anodes  <= w_an_nxt;
      r_bcd     <= w_bcd_nxt;
      r_tick    <= w_wrap;
    end
  end

  assign bcd_out    = r_bcd;
  assign anodes     = r_anodes;
  assign digit_idx  = r_idx;
  assign frame_tick = r_tick;
  assign pending    = r_pending;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: per-slot scoreboard plus directed checks.
// Two instances share stimulus: blanking on and blanking off.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;

  logic [3:0]  bcd_out, bcd2;
  logic [3:0]  anodes, anodes2;
  logic [1:0]  digit_idx, idx2;
  logic        frame_tick, tick2;
  logic        pending, pend2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] bcd;
    logic [3:0] bcd2;
  } exp_t;

  exp_t q[$];

  display_scan_ctrl #(
    .N_DIGITS(4), .DIV(8), .GAP(2), .LZ_BLANK(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .digits_in(digits_in), .bcd_out(bcd_out),
    .anodes(anodes), .digit_idx(digit_idx),
    .frame_tick(frame_tick), .pending(pending)
  );

  display_scan_ctrl #(
    .N_DIGITS(4), .DIV(8), .GAP(2), .LZ_BLANK(1'b0)
  ) u_nolz (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .digits_in(digits_in), .bcd_out(bcd2),
    .anodes(anodes2), .digit_idx(idx2),
    .frame_tick(tick2), .pending(pend2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    chk("wait_tick", 16'(seen), 16'd1);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    digits_in = v;
    step(1);
    load = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] lz,
                            input logic [15:0] nolz,
                            input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx  = 2'(i);
      e.bcd  = lz[4*i +: 4];
      e.bcd2 = nolz[4*i +: 4];
      q.push_back(e);
    end
  endtask

  task automatic chk_pend(input string nm, input logic exp);
    chk(nm, 16'(pending), 16'(exp));
    chk({nm, "_b"}, 16'(pend2), 16'(exp));
  endtask

  // Monitor: a slot is presented when an anode turns on.
  initial begin : mon
    logic       prev;
    logic [3:0] an_exp;
    exp_t       e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (anodes != 4'hF && !prev && q.size() > 0) begin
        e = q.pop_front();
        an_exp = ~(4'b0001 << e.idx);
        chk("sb_idx", 16'(digit_idx), 16'(e.idx));
        chk("sb_an", 16'(anodes), 16'(an_exp));
        chk("sb_an_b", 16'(anodes2), 16'(an_exp));
        chk("sb_bcd", 16'(bcd_out), 16'(e.bcd));
        chk("sb_bcd_b", 16'(bcd2), 16'(e.bcd2));
      end
      prev = (anodes != 4'hF);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time %0t limit 200000", $time);
    $fatal(1, "timeout");
  end

  logic [15:0] lz_in[3]  = '{16'h0050, 16'h0000, 16'h0A00};
  logic [15:0] lz_exp[3] = '{16'hFF50, 16'hFFF0, 16'hFA00};
  logic [15:0] nz_exp[3] = '{16'h0050, 16'h0000, 16'h0A00};

  initial begin : stim
    logic [3:0] a_exp;
    int         cyc;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_an", 16'(anodes), 16'hF);
    chk("rst_bcd", 16'(bcd_out), 16'hF);
    chk("rst_idx", 16'(digit_idx), 16'd0);
    chk("rst_tick", 16'(frame_tick), 16'd0);
    chk_pend("rst_pend", 1'b0);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("off_an", 16'(anodes), 16'hF);
    chk("off_bcd", 16'(bcd_out), 16'hF);

    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (k < 2 || (k >= 8 && k < 10)) a_exp = 4'hF;
      else if (k < 8) a_exp = 4'hE;
      else a_exp = 4'hD;
      chk($sformatf("ramp%0d", k), 16'(anodes), 16'(a_exp));
    end

    wait_tick();
    chk("tick_idx", 16'(digit_idx), 16'd0);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      cyc++;
      if (frame_tick) break;
    end
    chk("tick_period", 16'(cyc), 16'd32);

    // Load mid-frame: rest of this frame keeps the old value.
    push_frame(16'hFFFF, 16'hFFFF, 4);
    step(4);
    do_load(16'h1234);
    chk_pend("pend_set", 1'b1);
    wait_tick();
    chk_pend("pend_clr", 1'b0);
    push_frame(16'h1234, 16'h1234, 4);

    for (int v = 0; v < 3; v++) begin
      step(4);
      do_load(lz_in[v]);
      wait_tick();
      chk_pend($sformatf("lz_pend%0d", v), 1'b0);
      push_frame(lz_exp[v], nz_exp[v], 4);
    end

    // Load on the exact boundary edge.
    step(4);
    do_load(16'h1111);
    step(26);
    do_load(16'h2222);
    chk("sim_tick", 16'(frame_tick), 16'd1);
    chk_pend("sim_pend", 1'b1);
    push_frame(16'h1111, 16'h1111, 4);
    wait_tick();
    chk_pend("sim_pend2", 1'b0);
    push_frame(16'h2222, 16'h2222, 3);

    // Drop enable during digit 2 SHOW.
    step(4);
    do_load(16'h3333);
    step(14);
    chk("drop_pre_idx", 16'(digit_idx), 16'd2);
    chk("drop_pre_an", 16'(anodes), 16'hB);
    en = 1'b0;
    step(1);
    chk("drop_an", 16'(anodes), 16'hF);
    chk("drop_bcd", 16'(bcd_out), 16'hF);
    chk("drop_idx", 16'(digit_idx), 16'd0);
    chk("drop_tick", 16'(frame_tick), 16'd0);
    chk_pend("drop_pend", 1'b1);
    step(3);
    chk("drop_hold_an", 16'(anodes), 16'hF);
    en = 1'b1;
    step(1);
    chk("reen_idx", 16'(digit_idx), 16'd0);
    chk("reen_an", 16'(anodes), 16'hF);
    chk("reen_bcd", 16'(bcd_out), 16'h2);
    chk_pend("reen_pend", 1'b1);
    push_frame(16'h2222, 16'h2222, 4);
    wait_tick();
    chk_pend("reen_commit", 1'b0);
    push_frame(16'h3333, 16'h3333, 1);

    // Async reset during SHOW with a pending value.
    step(4);
    do_load(16'h4444);
    chk_pend("ar_pend_pre", 1'b1);
    step(1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_an", 16'(anodes), 16'hF);
    chk("ar_bcd", 16'(bcd_out), 16'hF);
    chk("ar_idx", 16'(digit_idx), 16'd0);
    chk("ar_tick", 16'(frame_tick), 16'd0);
    chk_pend("ar_pend", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(16'hFFFF, 16'hFFFF, 4);
    wait_tick();
    chk_pend("ar_pend_post", 1'b0);
    chk("ar_tick_idx", 16'(digit_idx), 16'd0);
    push_frame(16'hFFFF, 16'hFFFF, 4);
    wait_tick();
    chk("sb_drained", 16'(q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
